// File: rtl/spi_ram_pkg.sv
// Shared command encodings, widths and control-state type for the SPI RAM.
package spi_ram_pkg;

  localparam int DATA_W = 8;
  localparam int CMD_W  = 2;
  localparam int DIN_W  = CMD_W + DATA_W;

  localparam logic [CMD_W-1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [CMD_W-1:0] CMD_WR_DATA = 2'b01;
  localparam logic [CMD_W-1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [CMD_W-1:0] CMD_RD_DATA = 2'b11;

  // Bit 0 = write address armed, bit 1 = read address armed.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WR_RDY   = 2'b01,
    RD_RDY   = 2'b10,
    BOTH_RDY = 2'b11
  } ctrl_state_e;

endpackage

// File: rtl/spi_ram_core.sv
// Storage array for the SPI RAM: synchronous write port and a registered,
// enabled read port. Only the read register is reset; the array keeps its contents.
module spi_ram_core
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = $clog2(MEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram.sv
// Command decoder for the RAM behind the SPI slave: address registers, armed
// flags and tx_valid. Define SPI_RAM_AUTOINC_EN to post-increment addresses.
module spi_ram
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIN_W-1:0]  din,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid
);

  logic [CMD_W-1:0]     cmd;
  logic [ADDR_SIZE-1:0] addr_in;
  logic [DATA_W-1:0]    payload;
  logic                 accept;

  ctrl_state_e          state_q, state_d;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 tx_valid_q, tx_valid_d;

  logic                 wr_armed, rd_armed;
  logic                 wr_armed_nxt, rd_armed_nxt;
  logic                 mem_we, mem_re;

  assign cmd      = din[DIN_W-1:DATA_W];
  assign payload  = din[DATA_W-1:0];
  assign addr_in  = payload[ADDR_SIZE-1:0];
  // Reset wins over a word arriving on the same edge.
  assign accept   = rx_valid && !rst;
  assign wr_armed = (state_q == WR_RDY) || (state_q == BOTH_RDY);
  assign rd_armed = (state_q == RD_RDY) || (state_q == BOTH_RDY);

  always_comb begin
    wr_armed_nxt = wr_armed;
    rd_armed_nxt = rd_armed;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    tx_valid_d   = tx_valid_q;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    if (accept) begin
      tx_valid_d = 1'b0;
      case (cmd)
        CMD_WR_ADDR: begin
          wr_addr_d    = addr_in;
          wr_armed_nxt = 1'b1;
        end
        CMD_WR_DATA: begin
          if (wr_armed) begin
            mem_we = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
            wr_addr_d = wr_addr_q + ADDR_SIZE'(1);
`endif
          end
        end
        CMD_RD_ADDR: begin
          rd_addr_d    = addr_in;
          rd_armed_nxt = 1'b1;
        end
        default: begin
          if (rd_armed) begin
            mem_re     = 1'b1;
            tx_valid_d = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
            rd_addr_d = rd_addr_q + ADDR_SIZE'(1);
`endif
          end
        end
      endcase
    end
    state_d = ctrl_state_e'({rd_armed_nxt, wr_armed_nxt});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  spi_ram_core #(
    .MEM_DEPTH(MEM_DEPTH),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .we   (mem_we),
    .waddr(wr_addr_q),
    .wdata(payload),
    .re   (mem_re),
    .raddr(rd_addr_q),
    .rdata(dout)
  );

  assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_spi_ram.sv
// Scoreboard bench for spi_ram: directed command sequences plus random traffic
// checked every cycle against a behavioural model of the command set.
module tb_spi_ram;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [9:0] din = '0;
  logic [7:0] dout;
  logic       tx_valid;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit         tx;
    logic [7:0] data;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  logic [7:0] m_mem [256];
  bit         m_wr_armed, m_rd_armed;
  int         m_wr_addr, m_rd_addr;
  bit         m_tx;
  logic [7:0] m_dout;

  spi_ram dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .rx_valid(rx_valid),
    .dout    (dout),
    .tx_valid(tx_valid)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input string what,
                              input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s %s: got 0x%02h, expected 0x%02h", tag, what, act, exp);
    end
  endtask

  // Reference behaviour of one clock edge, straight from the command rules.
  task automatic model_step(input bit r, input bit v, input logic [9:0] w);
    int p;
    p = int'(w[7:0]) % 256;
    if (r) begin
      m_tx = 0; m_dout = 8'h00;
      m_wr_armed = 0; m_rd_armed = 0;
      m_wr_addr = 0; m_rd_addr = 0;
    end else if (v) begin
      m_tx = 0;
      case (w[9:8])
        2'b00: begin m_wr_addr = p; m_wr_armed = 1; end
        2'b01: if (m_wr_armed) begin
          m_mem[m_wr_addr] = w[7:0];
`ifdef SPI_RAM_AUTOINC_EN
          m_wr_addr = (m_wr_addr + 1) % 256;
`endif
        end
        2'b10: begin m_rd_addr = p; m_rd_armed = 1; end
        default: if (m_rd_armed) begin
          m_dout = m_mem[m_rd_addr];
          m_tx = 1;
`ifdef SPI_RAM_AUTOINC_EN
          m_rd_addr = (m_rd_addr + 1) % 256;
`endif
        end
      endcase
    end
  endtask

  task automatic apply_stimulus(input bit r, input bit v, input logic [9:0] w,
                                input string tag);
    exp_t e;
    @(negedge clk);
    rst = r; rx_valid = v; din = w;
    model_step(r, v, w);
    e.tx = m_tx; e.data = m_dout; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [9:0] w, input string tag);
    apply_stimulus(1'b0, 1'b1, w, tag);
  endtask

  task automatic idle(input string tag);
    apply_stimulus(1'b0, 1'b0, 10'h000, tag);
  endtask

  // Monitor: compares DUT outputs after every driven edge against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output(e.tag, "tx_valid", {7'd0, tx_valid}, {7'd0, e.tx});
        check_output(e.tag, "dout", dout, e.data);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    model_step(1'b1, 1'b0, 10'h000);

    apply_stimulus(1'b1, 1'b0, 10'h000, "reset");
    apply_stimulus(1'b1, 1'b0, 10'h000, "reset");
    send(10'h300, "t1_rd_unarmed");
    idle("t1_idle");
    check_output("t1_const", "dout", dout, 8'h00);

    send(10'h00A, "t2_wr_addr");
    send(10'h16D, "t2_wr_data");
    send(10'h20A, "t2_rd_addr");
    send(10'h300, "t2_rd_data");
    idle("t2_idle");
    check_output("t2_const", "dout", dout, 8'h6D);
    check_output("t2_const", "tx_valid", {7'd0, tx_valid}, 8'h01);

    for (int i = 0; i < 9; i++) idle("t3_hold");
    check_output("t3_const", "tx_valid", {7'd0, tx_valid}, 8'h01);
    send(10'h001, "t3_wr_addr_clears");
    idle("t3_idle");
    check_output("t3_const_clr", "tx_valid", {7'd0, tx_valid}, 8'h00);

    send(10'h0FF, "t4_wr_addr");
    send(10'h1A5, "t4_wr_data");
    send(10'h2FF, "t4_rd_addr");
    send(10'h300, "t4_rd_data");
    idle("t4_idle");
    check_output("t4_const", "dout", dout, 8'hA5);
`ifdef SPI_RAM_AUTOINC_EN
    send(10'h13C, "t4_wr_wrap");
    send(10'h300, "t4_rd_wrap");
    idle("t4_idle_wrap");
    check_output("t4_const_wrap", "dout", dout, 8'h3C);
`endif

    apply_stimulus(1'b1, 1'b1, 10'h300, "t5_rst_rd");
    send(10'h300, "t5_rd_dropped");
    send(10'h20A, "t5_rd_addr");
    send(10'h300, "t5_rd_data");
    idle("t5_idle");
    check_output("t5_const", "dout", dout, 8'h6D);

    send(10'h006, "t6_wr_addr6");
    send(10'h122, "t6_wr_data6");
    send(10'h005, "t6_wr_addr5");
    send(10'h111, "t6_wr_data5");
    send(10'h205, "t6_rd_addr");
    send(10'h300, "t6_rd_n");
    send(10'h300, "t6_rd_n1");
    idle("t6_idle");

    for (int i = 0; i < 256; i++) begin
      send({2'b00, 8'(i)}, "init_addr");
      send({2'b01, 8'($urandom_range(0, 255))}, "init_data");
    end

    for (int i = 0; i < 600; i++) begin
      apply_stimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                     10'($urandom_range(0, 1023)), "random");
    end
    idle("drain");

    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
